vector_line_draw: RTL and testbench

Line generator for the vector display path: responder to the vector list manager's `go`/`busy` handshake. On `go` it latches start and end coordinates and walks an integer Bresenham line from start to end, driving the X/Y DAC codes one point at a time. It holds `busy` until the last point has dwelt, then returns to idle. Zero-length lines (beam positioning moves) produce a single dwelled point.

---
 rtl/vector_pkg.sv | 28 ++
 rtl/vector_line_draw.sv | 175 +++++++++++++++++
 tb/tb_vector_line_draw.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// ---------------------------------------------------------------------------
// vector_pkg
//   Shared types and sizing helpers for the vector display line path.
//
//   line_state_t : FSM states of the line generator (IDLE, SETUP, STEP).
//   ERR_GUARD_BITS / err_width(): the Bresenham error terms (dx, dy, err, e2)
//     need two bits beyond the coordinate width. One bit holds the sign. The
//     other bit covers the doubled error at full-scale extents.
//   DWELL_W      : width of the per-point dwell counter. STEP_CYCLES is at
//     most 255, so 8 bits are enough.
// ---------------------------------------------------------------------------
package vector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    STEP  = 2'd2
  } line_state_t;

  localparam int ERR_GUARD_BITS = 2;
  localparam int DWELL_W        = 8;

  // Signed width of the error terms for a given coordinate width.
  function automatic int err_width(input int out_w);
    return out_w + ERR_GUARD_BITS;
  endfunction

endpackage

// File: rtl/vector_line_draw.sv
// ---------------------------------------------------------------------------
// vector_line_draw
//   Bresenham line generator that responds to the vector list manager's
//   go/busy handshake. On an accepted go, the block latches the start and end
//   points. It then spends one SETUP cycle deriving the error terms and
//   showing the start point. After that it steps one point at a time, and
//   each point is held on the DAC for STEP_CYCLES clocks. Busy stays high
//   until the last point has finished its dwell. A zero-length line gives a
//   single point that dwells for STEP_CYCLES clocks.
//
// Parameters
//   OUT_WIDTH    : coordinate / DAC code width (unsigned)
//   STEP_CYCLES  : clocks each point is held, 1..255
//
// Ports
//   clk                  : system clock, rising edge
//   rst_n                : asynchronous active-low reset
//   go                   : start request, sampled only while idle
//   stax, stay           : line start point
//   endx, endy           : line end point
//   busy                 : high from the cycle after go is accepted until
//                          the line completes
//   dac_x, dac_y         : current beam position; hold the last end point
//                          while idle
//   point_strobe         : one-cycle pulse on every DAC load
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module vector_line_draw
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH   = 8,
  parameter int STEP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic [OUT_WIDTH-1:0] stax,
  input  logic [OUT_WIDTH-1:0] stay,
  input  logic [OUT_WIDTH-1:0] endx,
  input  logic [OUT_WIDTH-1:0] endy,
  output logic                 busy,
  output logic [OUT_WIDTH-1:0] dac_x,
  output logic [OUT_WIDTH-1:0] dac_y,
  output logic                 point_strobe
);

  localparam int ERR_W = err_width(OUT_WIDTH);
  localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(STEP_CYCLES - 1);

  // Registers
  line_state_t                r_state;
  logic [OUT_WIDTH-1:0]       r_stax;
  logic [OUT_WIDTH-1:0]       r_stay;
  logic [OUT_WIDTH-1:0]       r_endx;
  logic [OUT_WIDTH-1:0]       r_endy;
  logic signed [ERR_W-1:0]    r_dx;
  logic signed [ERR_W-1:0]    r_dy;
  logic signed [ERR_W-1:0]    r_err;
  logic                       r_sx_neg;
  logic                       r_sy_neg;
  logic [DWELL_W-1:0]         r_cnt;

  // SETUP-time geometry
  logic signed [ERR_W-1:0]    w_ddx;
  logic signed [ERR_W-1:0]    w_ddy;
  logic signed [ERR_W-1:0]    w_dx;
  logic signed [ERR_W-1:0]    w_dy;

  // STEP-time Bresenham update
  logic signed [ERR_W-1:0]    w_e2;
  logic                       w_step_x;
  logic                       w_step_y;
  logic signed [ERR_W-1:0]    w_err_next;
  logic [OUT_WIDTH-1:0]       w_next_x;
  logic [OUT_WIDTH-1:0]       w_next_y;
  logic                       w_at_end;

  always_comb begin
    // The coordinates are zero-extended into the wider signed domain, so the
    // differences stay exact across the full unsigned range.
    w_ddx = $signed({{ERR_GUARD_BITS{1'b0}}, r_endx})
          - $signed({{ERR_GUARD_BITS{1'b0}}, r_stax});
    w_ddy = $signed({{ERR_GUARD_BITS{1'b0}}, r_endy})
          - $signed({{ERR_GUARD_BITS{1'b0}}, r_stay});
    w_dx  = (w_ddx < 0) ? -w_ddx : w_ddx;
    // dy is held as a negative magnitude. This matches the textbook form,
    // where err = dx + dy.
    w_dy  = (w_ddy < 0) ? w_ddy : -w_ddy;
  end

  always_comb begin
    // err always lies within [dy, dx], so doubling it cannot overflow ERR_W.
    w_e2       = r_err <<< 1;
    w_step_x   = (w_e2 >= r_dy);
    w_step_y   = (w_e2 <= r_dx);
    // Both increments are taken from the old err value.
    w_err_next = r_err;
    if (w_step_x) w_err_next = w_err_next + r_dy;
    if (w_step_y) w_err_next = w_err_next + r_dx;

    w_next_x = dac_x;
    if (w_step_x) w_next_x = r_sx_neg ? (dac_x - OUT_WIDTH'(1)) : (dac_x + OUT_WIDTH'(1));
    w_next_y = dac_y;
    if (w_step_y) w_next_y = r_sy_neg ? (dac_y - OUT_WIDTH'(1)) : (dac_y + OUT_WIDTH'(1));

    w_at_end = (dac_x == r_endx) && (dac_y == r_endy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_stax       <= '0;
      r_stay       <= '0;
      r_endx       <= '0;
      r_endy       <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_err        <= '0;
      r_sx_neg     <= 1'b0;
      r_sy_neg     <= 1'b0;
      r_cnt        <= '0;
      busy         <= 1'b0;
      dac_x        <= '0;
      dac_y        <= '0;
      point_strobe <= 1'b0;
    end else begin
      point_strobe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (go) begin
            r_stax  <= stax;
            r_stay  <= stay;
            r_endx  <= endx;
            r_endy  <= endy;
            busy    <= 1'b1;
            r_state <= SETUP;
          end
        end

        SETUP: begin
          r_dx         <= w_dx;
          r_dy         <= w_dy;
          r_sx_neg     <= (w_ddx < 0);
          r_sy_neg     <= (w_ddy < 0);
          r_err        <= w_dx + w_dy;
          dac_x        <= r_stax;
          dac_y        <= r_stay;
          point_strobe <= 1'b1;
          r_cnt        <= DWELL_RELOAD;
          r_state      <= STEP;
        end

        STEP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end else if (w_at_end) begin
            // The last point has finished its dwell.
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_err        <= w_err_next;
            dac_x        <= w_next_x;
            dac_y        <= w_next_y;
            point_strobe <= 1'b1;
            r_cnt        <= DWELL_RELOAD;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_line_draw.sv
module tb_vector_line_draw;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         go = 1'b0;
  logic [W-1:0] stax = '0;
  logic [W-1:0] stay = '0;
  logic [W-1:0] endx = '0;
  logic [W-1:0] endy = '0;
  logic         busy;
  logic [W-1:0] dac_x;
  logic [W-1:0] dac_y;
  logic         point_strobe;

  always #5 clk = ~clk;

  vector_line_draw #(.OUT_WIDTH(W), .STEP_CYCLES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .stax         (stax),
    .stay         (stay),
    .endx         (endx),
    .endy         (endy),
    .busy         (busy),
    .dac_x        (dac_x),
    .dac_y        (dac_y),
    .point_strobe (point_strobe)
  );

  typedef struct {int x; int y;} pt_t;
  typedef struct {int n; int blen;} line_t;

  pt_t   pt_q[$];
  line_t line_q[$];

  int errors = 0;
  int checks = 0;
  int line_strobes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the textbook integer Bresenham walk, computed in plain ints.
  function automatic int ref_line(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y, n;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    x = x0; y = y0; n = 0;
    for (int guard = 0; guard < 1000; guard++) begin
      pt_q.push_back('{x: x, y: y});
      n++;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    return n;
  endfunction

  // Monitor: pops expected points on every strobe, checks dwell holds and busy length.
  initial begin
    int busy_len;
    bit prev_busy;
    int prev_x, prev_y;
    pt_t p;
    line_t l;
    busy_len = 0; prev_busy = 0; prev_x = 0; prev_y = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_busy", int'(busy), 0);
        check("rst_strobe", int'(point_strobe), 0);
        check("rst_dac_x", int'(dac_x), 0);
        check("rst_dac_y", int'(dac_y), 0);
        busy_len = 0; line_strobes = 0; prev_busy = 0; prev_x = 0; prev_y = 0;
      end else begin
        if (point_strobe) begin
          if (pt_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
          end else begin
            p = pt_q.pop_front();
            check("pt_x", int'(dac_x), p.x);
            check("pt_y", int'(dac_y), p.y);
          end
          line_strobes++;
        end else begin
          check("hold_x", int'(dac_x), prev_x);
          check("hold_y", int'(dac_y), prev_y);
        end
        if (busy) begin
          busy_len++;
        end else if (prev_busy) begin
          if (line_q.size() == 0) begin
            check("unexpected_line", 1, 0);
          end else begin
            l = line_q.pop_front();
            check("busy_len", busy_len, l.blen);
            check("n_points", line_strobes, l.n);
          end
          busy_len = 0;
          line_strobes = 0;
        end
        prev_busy = busy;
        prev_x = int'(dac_x);
        prev_y = int'(dac_y);
      end
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(posedge clk); #2;
    while (busy && guard < 3000) begin
      @(posedge clk); #2;
      guard++;
    end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic issue_line(input int x0, input int y0, input int x1, input int y1);
    int n;
    wait_idle();
    stax = W'(x0); stay = W'(y0); endx = W'(x1); endy = W'(y1);
    go = 1'b1;
    n = ref_line(x0, y0, x1, y1);
    line_q.push_back('{n: n, blen: 1 + n * S});
    @(posedge clk); #2;
    go = 1'b0;
    check("busy_rise", int'(busy), 1);
  endtask

  task automatic check_rest(input int x, input int y);
    wait_idle();
    check("idle_hold_x", int'(dac_x), x);
    check("idle_hold_y", int'(dac_y), y);
  endtask

  initial begin
    int x0, y0, x1, y1, guard;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    check("idle_busy", int'(busy), 0);

    issue_line(0, 5, 3, 5);
    check_rest(3, 5);
    issue_line(0, 0, 3, 3);
    check_rest(3, 3);
    issue_line(10, 10, 8, 15);
    check_rest(8, 15);

    // Zero-length line plus a go pulsed while busy, which must be ignored.
    issue_line(200, 40, 200, 40);
    stax = 8'd1; stay = 8'd2; endx = 8'd3; endy = 8'd4;
    go = 1'b1;
    @(posedge clk); #2;
    go = 1'b0;
    issue_line(7, 9, 12, 6);
    check_rest(12, 6);

    // Full-scale line, interrupted by reset at point 100.
    issue_line(255, 0, 0, 255);
    guard = 0;
    while (line_strobes < 100 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reach_pt100", line_strobes >= 100 ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_dac_x", int'(dac_x), 0);
    check("async_dac_y", int'(dac_y), 0);
    check("async_strobe", int'(point_strobe), 0);
    pt_q.delete();
    line_q.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    issue_line(255, 0, 0, 255);
    check_rest(0, 255);

    for (int i = 0; i < 25; i++) begin
      x0 = $urandom_range(0, 255);
      y0 = $urandom_range(0, 255);
      if (i % 8 == 0) begin
        x1 = $urandom_range(0, 255);
        y1 = $urandom_range(0, 255);
      end else begin
        x1 = x0 + $urandom_range(0, 40) - 20;
        y1 = y0 + $urandom_range(0, 40) - 20;
        if (x1 < 0) x1 = 0;
        if (x1 > 255) x1 = 255;
        if (y1 < 0) y1 = 0;
        if (y1 > 255) y1 = 255;
      end
      issue_line(x0, y0, x1, y1);
      if (i % 5 == 0) check_rest(x1, y1);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    check("pt_q_drained", pt_q.size(), 0);
    check("line_q_drained", line_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
